// File: rtl/chimp_control.sv
// Round sequencer for the Chimp memory game: clears the board, loads numbers
// 1..level into free cells, tracks the player's next number, strikes and levels.
module chimp_control #(
    parameter int START_LEVEL = 4,
    parameter int MAX_LEVEL   = 31,
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iStart,
    input  logic       iContinue,
    input  logic       iDoneLoad,
    input  logic       iChoseCorrect,
    input  logic       iChoseWrong,
    output logic       oResetBoard,
    output logic       oLoadEnable,
    output logic [4:0] oLoadNum,
    output logic [4:0] oChooseNum,
    output logic       oHideNumbers,
    output logic [4:0] oLevel,
    output logic [4:0] oScore,
    output logic [1:0] oStrikes,
    output logic       oRoundWon,
    output logic       oGameOver,
    output logic [2:0] oState
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CLEAR      = 3'd1;
    localparam logic [2:0] S_LOAD_REQ   = 3'd2;
    localparam logic [2:0] S_LOAD_WAIT  = 3'd3;
    localparam logic [2:0] S_PLAY       = 3'd4;
    localparam logic [2:0] S_ROUND_WIN  = 3'd5;
    localparam logic [2:0] S_ROUND_LOSE = 3'd6;
    localparam logic [2:0] S_GAME_OVER  = 3'd7;

    localparam logic [4:0] START_LVL  = 5'(START_LEVEL);
    localparam logic [4:0] MAX_LVL    = 5'(MAX_LEVEL);
    localparam logic [1:0] STRIKE_LIM = 2'(MAX_STRIKES);

    logic [2:0] state_r,      state_s;
    logic [4:0] level_r,      level_s;
    logic [4:0] score_r,      score_s;
    logic [1:0] strikes_r,    strikes_s;
    logic [4:0] load_num_r,   load_num_s;
    logic [4:0] choose_num_r, choose_num_s;
    logic       hide_r,       hide_s;
    logic [1:0] strike_inc_s;

    // Next-state and datapath-register decode for one round of play
    always_comb begin
        state_s      = state_r;
        level_s      = level_r;
        score_s      = score_r;
        strikes_s    = strikes_r;
        load_num_s   = load_num_r;
        choose_num_s = choose_num_r;
        hide_s       = hide_r;
        strike_inc_s = strikes_r + 2'd1;

        case (state_r)
            S_IDLE, S_GAME_OVER: begin
                if (iStart) begin
                    state_s   = S_CLEAR;
                    level_s   = START_LVL;
                    strikes_s = 2'd0;
                    score_s   = 5'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_CLEAR: begin
                load_num_s   = 5'd1;
                choose_num_s = 5'd1;
                hide_s       = 1'b0;
                state_s      = S_LOAD_REQ;
            end
            S_LOAD_REQ: begin
                state_s = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                // A missed load means the random cell was occupied: retry the same number
                if (!iDoneLoad) begin
                    state_s = S_LOAD_REQ;
                end else if (load_num_r == level_r) begin
                    state_s = S_PLAY;
                end else begin
                    load_num_s = load_num_r + 5'd1;
                    state_s    = S_LOAD_REQ;
                end
            end
            S_PLAY: begin
                // Wrong has priority so a simultaneous pair costs exactly one strike
                if (iChoseWrong) begin
                    strikes_s = strike_inc_s;
                    if (strike_inc_s == STRIKE_LIM) begin
                        state_s = S_GAME_OVER;
                    end else begin
                        state_s = S_ROUND_LOSE;
                    end
                end else if (iChoseCorrect) begin
                    hide_s = 1'b1;
                    if (choose_num_r == level_r) begin
                        score_s = level_r;
                        state_s = S_ROUND_WIN;
                    end else begin
                        choose_num_s = choose_num_r + 5'd1;
                        state_s      = S_PLAY;
                    end
                end else begin
                    state_s = S_PLAY;
                end
            end
            S_ROUND_WIN: begin
                if (iContinue) begin
                    if (level_r == MAX_LVL) begin
                        state_s = S_GAME_OVER;
                    end else begin
                        level_s = level_r + 5'd1;
                        state_s = S_CLEAR;
                    end
                end else begin
                    state_s = S_ROUND_WIN;
                end
            end
            S_ROUND_LOSE: begin
                if (iContinue) begin
                    state_s = S_CLEAR;
                end else begin
                    state_s = S_ROUND_LOSE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and round registers
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_r      <= S_IDLE;
            level_r      <= 5'd0;
            score_r      <= 5'd0;
            strikes_r    <= 2'd0;
            load_num_r   <= 5'd0;
            choose_num_r <= 5'd0;
            hide_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            level_r      <= level_s;
            score_r      <= score_s;
            strikes_r    <= strikes_s;
            load_num_r   <= load_num_s;
            choose_num_r <= choose_num_s;
            hide_r       <= hide_s;
        end
    end

    // Outputs come straight from registers or a decode of the registered state
    assign oResetBoard  = (state_r == S_CLEAR);
    assign oLoadEnable  = (state_r == S_LOAD_REQ);
    assign oLoadNum     = load_num_r;
    assign oChooseNum   = choose_num_r;
    assign oHideNumbers = hide_r;
    assign oLevel       = level_r;
    assign oScore       = score_r;
    assign oStrikes     = strikes_r;
    assign oRoundWon    = (state_r == S_ROUND_WIN);
    assign oGameOver    = (state_r == S_GAME_OVER);
    assign oState       = state_r;

endmodule

// File: tb/tb_chimp_control.sv
// Directed bench for chimp_control: a vector table for the first round, then
// hand-written sequences for strikes, reset mid-load and the max-level case.
module tb_chimp_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_start = 1'b0, in_cont = 1'b0, in_done = 1'b0, in_cor = 1'b0, in_wrong = 1'b0;
    logic sel = 1'b0;

    logic       rb0, le0, hide0, won0, go0, rb1, le1, hide1, won1, go1;
    logic [4:0] ln0, cn0, lv0, sc0, ln1, cn1, lv1, sc1;
    logic [1:0] sk0, sk1;
    logic [2:0] st0, st1;

    logic       o_rb, o_le, o_hide, o_won, o_go;
    logic [4:0] o_ln, o_cn, o_lv, o_sc;
    logic [1:0] o_sk;
    logic [2:0] o_st;
    logic [29:0] obs;

    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_START = 5'b10000;
    localparam logic [4:0] I_CONT  = 5'b01000;
    localparam logic [4:0] I_DONE  = 5'b00100;
    localparam logic [4:0] I_COR   = 5'b00010;
    localparam logic [4:0] I_WRONG = 5'b00001;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chimp_control #(.START_LEVEL(4), .MAX_LEVEL(31), .MAX_STRIKES(3)) dut0 (
        .clk(clk), .iResetn(rst_n), .iStart(in_start), .iContinue(in_cont),
        .iDoneLoad(in_done), .iChoseCorrect(in_cor), .iChoseWrong(in_wrong),
        .oResetBoard(rb0), .oLoadEnable(le0), .oLoadNum(ln0), .oChooseNum(cn0),
        .oHideNumbers(hide0), .oLevel(lv0), .oScore(sc0), .oStrikes(sk0),
        .oRoundWon(won0), .oGameOver(go0), .oState(st0)
    );

    chimp_control #(.START_LEVEL(2), .MAX_LEVEL(2), .MAX_STRIKES(3)) dut1 (
        .clk(clk), .iResetn(rst_n), .iStart(in_start), .iContinue(in_cont),
        .iDoneLoad(in_done), .iChoseCorrect(in_cor), .iChoseWrong(in_wrong),
        .oResetBoard(rb1), .oLoadEnable(le1), .oLoadNum(ln1), .oChooseNum(cn1),
        .oHideNumbers(hide1), .oLevel(lv1), .oScore(sc1), .oStrikes(sk1),
        .oRoundWon(won1), .oGameOver(go1), .oState(st1)
    );

    assign o_rb   = sel ? rb1   : rb0;
    assign o_le   = sel ? le1   : le0;
    assign o_ln   = sel ? ln1   : ln0;
    assign o_cn   = sel ? cn1   : cn0;
    assign o_hide = sel ? hide1 : hide0;
    assign o_lv   = sel ? lv1   : lv0;
    assign o_sc   = sel ? sc1   : sc0;
    assign o_sk   = sel ? sk1   : sk0;
    assign o_won  = sel ? won1  : won0;
    assign o_go   = sel ? go1   : go0;
    assign o_st   = sel ? st1   : st0;
    assign obs = {o_st, o_rb, o_le, o_ln, o_cn, o_hide, o_lv, o_sc, o_sk, o_won, o_go};

    // Expected observation word; won/go follow from the expected state
    function automatic logic [29:0] ev(input int st, input int rb, input int le, input int ln,
                                       input int cn, input int h, input int lv, input int sc,
                                       input int sk);
        logic won, go;
        won = (st == 5);
        go  = (st == 7);
        return {3'(st), 1'(rb), 1'(le), 5'(ln), 5'(cn), 1'(h), 5'(lv), 5'(sc), 2'(sk), won, go};
    endfunction

    typedef struct {
        logic [4:0]  in;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic step(input logic [4:0] v);
        @(negedge clk);
        {in_start, in_cont, in_done, in_cor, in_wrong} = v;
        @(posedge clk);
        #1;
        {in_start, in_cont, in_done, in_cor, in_wrong} = 5'b00000;
    endtask

    // Runs from CLEAR to PLAY acknowledging every load; checks timing and pulses
    task automatic load_round(input int n, input string tag);
        int cyc = 0;
        int pulses = 0;
        int expn = 1;
        int bad_seq = 0;
        int consec = 0;
        logic prev_le = 1'b0;
        while (o_st != 3'd4 && cyc < 200) begin
            step((o_st == 3'd3) ? I_DONE : I_NONE);
            cyc++;
            if (o_le) begin
                pulses++;
                if (int'(o_ln) != expn) bad_seq++;
                expn++;
                if (prev_le) consec++;
            end
            prev_le = o_le;
        end
        chk({tag, "_cycles_to_play"}, cyc, 1 + 2 * n);
        chk({tag, "_load_pulses"}, pulses, n);
        chk({tag, "_loadnum_order_errors"}, bad_seq, 0);
        chk({tag, "_back_to_back_loads"}, consec, 0);
    endtask

    initial begin
        int le_seen;

        //          in                  st rb le ln cn h lv sc sk
        tbl[0]  = '{I_START,         ev(1, 1, 0, 0, 0, 0, 4, 0, 0)};
        tbl[1]  = '{I_START | I_CONT | I_COR,
                                     ev(2, 0, 1, 1, 1, 0, 4, 0, 0)};
        tbl[2]  = '{I_NONE,          ev(3, 0, 0, 1, 1, 0, 4, 0, 0)};
        tbl[3]  = '{I_DONE,          ev(2, 0, 1, 2, 1, 0, 4, 0, 0)};
        tbl[4]  = '{I_DONE,          ev(3, 0, 0, 2, 1, 0, 4, 0, 0)};
        tbl[5]  = '{I_NONE,          ev(2, 0, 1, 2, 1, 0, 4, 0, 0)};
        tbl[6]  = '{I_NONE,          ev(3, 0, 0, 2, 1, 0, 4, 0, 0)};
        tbl[7]  = '{I_DONE,          ev(2, 0, 1, 3, 1, 0, 4, 0, 0)};
        tbl[8]  = '{I_COR | I_WRONG, ev(3, 0, 0, 3, 1, 0, 4, 0, 0)};
        tbl[9]  = '{I_DONE,          ev(2, 0, 1, 4, 1, 0, 4, 0, 0)};
        tbl[10] = '{I_NONE,          ev(3, 0, 0, 4, 1, 0, 4, 0, 0)};
        tbl[11] = '{I_DONE,          ev(4, 0, 0, 4, 1, 0, 4, 0, 0)};
        tbl[12] = '{I_COR,           ev(4, 0, 0, 4, 2, 1, 4, 0, 0)};
        tbl[13] = '{I_CONT | I_START,ev(4, 0, 0, 4, 2, 1, 4, 0, 0)};
        tbl[14] = '{I_COR,           ev(4, 0, 0, 4, 3, 1, 4, 0, 0)};
        tbl[15] = '{I_COR,           ev(4, 0, 0, 4, 4, 1, 4, 0, 0)};
        tbl[16] = '{I_COR,           ev(5, 0, 0, 4, 4, 1, 4, 4, 0)};
        tbl[17] = '{I_START,         ev(5, 0, 0, 4, 4, 1, 4, 4, 0)};
        tbl[18] = '{I_CONT,          ev(1, 1, 0, 4, 4, 1, 5, 4, 0)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", int'(obs), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].in);
            n_checks++;
            if (obs == tbl[i].exp) n_pass++;
            else $display("FAIL vec%0d outputs actual=%h required=%h", i, obs, tbl[i].exp);
        end

        // Strikes across three rounds at level 5
        load_round(5, "lvl5_a");
        step(I_WRONG);
        chk("strike1_state", int'(o_st), 6);
        chk("strike1_count", int'(o_sk), 1);
        chk("strike1_level", int'(o_lv), 5);
        step(I_CONT | I_START);
        chk("lose_continue_state", int'(o_st), 1);
        chk("lose_continue_level", int'(o_lv), 5);
        load_round(5, "lvl5_b");
        step(I_COR);
        chk("b_first_correct_hide", int'(o_hide), 1);
        step(I_COR | I_WRONG);
        chk("both_pulses_state", int'(o_st), 6);
        chk("both_pulses_strikes", int'(o_sk), 2);
        chk("both_pulses_choose", int'(o_cn), 2);
        step(I_CONT);
        load_round(5, "lvl5_c");
        step(I_WRONG);
        chk("gameover_state", int'(o_st), 7);
        chk("gameover_flag", int'(o_go), 1);
        chk("gameover_strikes", int'(o_sk), 3);
        chk("gameover_score", int'(o_sc), 4);
        step(I_CONT | I_COR | I_WRONG | I_DONE);
        chk("gameover_hold_state", int'(o_st), 7);
        chk("gameover_hold_strikes", int'(o_sk), 3);

        // Restart and clean level-4 load
        step(I_START);
        chk("restart_state", int'(o_st), 1);
        chk("restart_level", int'(o_lv), 4);
        chk("restart_strikes", int'(o_sk), 0);
        chk("restart_score", int'(o_sc), 0);
        load_round(4, "clean4");

        // Reset during LOAD_WAIT
        step(I_WRONG);
        step(I_CONT);
        step(I_NONE);
        step(I_NONE);
        chk("pre_reset_in_wait", int'(o_st), 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(obs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        le_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(I_NONE);
            if (o_le) le_seen++;
        end
        chk("post_reset_no_loads", le_seen, 0);
        chk("post_reset_idle", int'(o_st), 0);

        // Max level: START_LEVEL = MAX_LEVEL = 2
        sel = 1'b1;
        step(I_START);
        chk("max_start_level", int'(o_lv), 2);
        load_round(2, "max");
        step(I_COR);
        chk("max_choose2", int'(o_cn), 2);
        step(I_COR);
        chk("max_round_won", int'(o_won), 1);
        chk("max_score", int'(o_sc), 2);
        step(I_CONT);
        chk("max_gameover_state", int'(o_st), 7);
        chk("max_gameover_score", int'(o_sc), 2);
        step(I_START);
        chk("max_restart_state", int'(o_st), 1);
        chk("max_restart_level", int'(o_lv), 2);
        chk("max_restart_strikes", int'(o_sk), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
